// File: rtl/bank_queue_dispatch_pkg.sv
// bank_q_pkg: shared overflow-mode constants, customer record and priority helper
package bank_q_pkg;

    localparam int MODE_DROP_NEW    = 0;
    localparam int MODE_DROP_OLDEST = 1;
    localparam int CUST_W           = 16;

    // Widest supported record; the top zero-extends narrower IDs/times into it.
    typedef struct packed {
        logic [CUST_W-1:0] num;
        logic [CUST_W-1:0] svc_time;
    } cust_t;

    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        lowest_set = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (v[i]) lowest_set = 3'(i);
    endfunction

endpackage

// File: rtl/bank_queue_dispatch_fifo.sv
// cust_fifo: circular customer FIFO with head-drop support and head-first flat view
module cust_fifo #(
    parameter int DEPTH = 3,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       drop_head_i,
    input  logic [W-1:0]               din_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic [W-1:0]               head_o,
    output logic [DEPTH*W-1:0]         flat_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q;
    logic          rd, wr;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];
    assign rd      = (pop_i | drop_head_i) & ~empty_o;
    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign wr      = push_i & (~full_o | rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (wr) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= inc(wr_q);
            end
            if (rd) rd_q <= inc(rd_q);
            cnt_q <= cnt_q + CW'(wr) - CW'(rd);
        end
    end

    always_comb begin
        flat_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < cnt_q)
                flat_o[i*W +: W] = mem_q[PW'((int'(rd_q) + i) % DEPTH)];
        end
    end

endmodule

// File: rtl/bank_queue_dispatch.sv
// bank_queue_dispatch: N service counters fed from a waiting FIFO, with
// bypass on empty queue, back-to-back reload and configurable overflow policy.
module bank_queue_dispatch
    import bank_q_pkg::*;
#(
    parameter int N_CNT  = 3,
    parameter int DEPTH  = 3,
    parameter int NUM_W  = 4,
    parameter int TIME_W = 4,
    parameter int CNT_W  = 8,
    parameter int MODE   = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid_i,
    input  logic [NUM_W-1:0]           in_num_i,
    input  logic [TIME_W-1:0]          in_time_i,
    output logic [N_CNT-1:0]           srv_busy_o,
    output logic [N_CNT*NUM_W-1:0]     srv_num_o,
    output logic [N_CNT*TIME_W-1:0]    srv_rem_o,
    output logic [$clog2(DEPTH+1)-1:0] q_count_o,
    output logic [DEPTH*NUM_W-1:0]     q_dbg_o,
    output logic [CNT_W-1:0]           drop_cnt_o,
    output logic [CNT_W-1:0]           srv_cnt_o
);
    localparam int W  = NUM_W + TIME_W;
    localparam int SW = (CNT_W > 4 ? CNT_W : 4) + 1;

    logic [N_CNT-1:0]   busy_q, avail, done, load;
    logic [NUM_W-1:0]   num_q [N_CNT];
    logic [TIME_W-1:0]  rem_q [N_CNT];
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d, srv_cnt_q, srv_cnt_d;
    logic [SW-1:0]      srv_sum;
    logic [3:0]         n_done;
    logic [2:0]         sel;
    logic               any_avail, pop, bypass, push_req, push, drop, drop_head;
    logic               full, empty;
    logic [W-1:0]       fifo_head;
    logic [DEPTH*W-1:0] fifo_flat;
    cust_t              arr_c, head_c, load_c;

    cust_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .pop_i       (pop),
        .drop_head_i (drop_head),
        .din_i       ({in_num_i, in_time_i}),
        .full_o      (full),
        .empty_o     (empty),
        .count_o     (q_count_o),
        .head_o      (fifo_head),
        .flat_o      (fifo_flat)
    );

    always_comb begin
        arr_c          = '0;
        arr_c.num      = CUST_W'(in_num_i);
        arr_c.svc_time = CUST_W'(in_time_i);
        head_c          = '0;
        head_c.num      = CUST_W'(fifo_head[W-1:TIME_W]);
        head_c.svc_time = CUST_W'(fifo_head[TIME_W-1:0]);
        any_avail = |avail;
        sel       = lowest_set(8'(avail));
        pop       = ~empty & any_avail;
        bypass    = empty & in_valid_i & any_avail;
        push_req  = in_valid_i & ~bypass;
        drop      = push_req & full & ~pop;
        drop_head = drop & (MODE == MODE_DROP_OLDEST);
        push      = push_req & ~(drop & (MODE == MODE_DROP_NEW));
        load_c    = pop ? head_c : arr_c;
        load      = (pop | bypass) ? (N_CNT'(1) << sel) : '0;
    end

    genvar g;
    for (g = 0; g < N_CNT; g++) begin : g_cnt
        assign done[g]  = busy_q[g] && rem_q[g] == TIME_W'(1);
        assign avail[g] = ~busy_q[g] | done[g];
        assign srv_num_o[g*NUM_W +: NUM_W]   = num_q[g];
        assign srv_rem_o[g*TIME_W +: TIME_W] = rem_q[g];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                busy_q[g] <= 1'b0;
                num_q[g]  <= '0;
                rem_q[g]  <= '0;
            end else if (load[g]) begin
                busy_q[g] <= 1'b1;
                num_q[g]  <= NUM_W'(load_c.num);
                rem_q[g]  <= (load_c.svc_time == '0) ? TIME_W'(1) : TIME_W'(load_c.svc_time);
            end else if (done[g]) begin
                busy_q[g] <= 1'b0;
                num_q[g]  <= '0;
                rem_q[g]  <= '0;
            end else if (busy_q[g]) begin
                rem_q[g] <= rem_q[g] - TIME_W'(1);
            end
        end
    end

    for (g = 0; g < DEPTH; g++) begin : g_dbg
        assign q_dbg_o[g*NUM_W +: NUM_W] = fifo_flat[g*W + TIME_W +: NUM_W];
    end

    // Several counters may finish on one edge, so served count adds a popcount.
    always_comb begin
        n_done = '0;
        for (int i = 0; i < N_CNT; i++) n_done = n_done + 4'(done[i]);
        srv_sum    = SW'(srv_cnt_q) + SW'(n_done);
        srv_cnt_d  = (srv_sum > SW'({CNT_W{1'b1}})) ? '1 : srv_sum[CNT_W-1:0];
        drop_cnt_d = (drop && drop_cnt_q != '1) ? drop_cnt_q + CNT_W'(1) : drop_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
            srv_cnt_q  <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            srv_cnt_q  <= srv_cnt_d;
        end
    end

    assign srv_busy_o = busy_q;
    assign drop_cnt_o = drop_cnt_q;
    assign srv_cnt_o  = srv_cnt_q;

endmodule
